// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1-to-2 demultiplexer.
package demux_pkg;

   localparam int DEMUX_W     = 64;
   localparam int DEMUX_NOUT  = 2;
   localparam int DEMUX_CNT_W = 16;

   // One output lane: holding register plus its valid flag.
   typedef struct packed {
      logic               valid;
      logic [DEMUX_W-1:0] data;
   } demux_slot_t;

   // Occupancy of a single lane slot.
   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

endpackage

// File: rtl/demux_slot_64.sv
// One-entry holding register for a single demux output lane.
// The slot state is the valid output itself (EMPTY -> 0, FULL -> 1).
// A load while FULL is only issued by the top when the same cycle drains,
// so a load always wins over a drain and never overwrites an undelivered word.
module demux_slot_64
   import demux_pkg::*;
#(
   parameter int WIDTH = DEMUX_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             drain,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   slot_state_t state_q;
   slot_state_t state_d;

   // Slot state register; reset discards any held word immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= SLOT_EMPTY;
      else       state_q <= state_d;
   end

   // Next-state: a load fills (or refills) the slot, a lone drain empties it.
   always_comb begin
      state_d = state_q;
      if (load)       state_d = SLOT_FULL;
      else if (drain) state_d = SLOT_EMPTY;
   end

   // Data register: only a load changes it, so data is stable while held.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)     data <= '0;
      else if (load) data <= load_data;
   end

   assign valid = (state_q == SLOT_FULL);

endmodule

// File: rtl/demux_64x1x2_reg.sv
// Registered 1-to-2 demultiplexer with a one-entry slot per output lane.
// Optional feature macro: DEMUX_ROUTE_COUNT_EN adds per-lane delivered-word
// counters cnt0/cnt1 (16-bit, wrapping).
//
// Handshake: a word moves across an interface on every rising edge where
// valid and ready are both 1. ready never depends on valid; a producer holding
// valid must keep its data stable until the transfer, and each output lane
// keeps outk_data stable while outk_valid = 1 and outk_ready = 0.
module demux_64x1x2_reg
   import demux_pkg::*;
#(
   parameter int WIDTH = DEMUX_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_valid,
   input  logic             out1_ready
`ifdef DEMUX_ROUTE_COUNT_EN
   ,
   output logic [DEMUX_CNT_W-1:0] cnt0,
   output logic [DEMUX_CNT_W-1:0] cnt1
`endif
);

   logic             lane_valid [DEMUX_NOUT];
   logic [WIDTH-1:0] lane_data  [DEMUX_NOUT];
   logic             lane_ready [DEMUX_NOUT];
   logic             lane_load  [DEMUX_NOUT];
   logic             lane_drain [DEMUX_NOUT];
   logic             acc;

   assign lane_ready[0] = out0_ready;
   assign lane_ready[1] = out1_ready;

   // The selected lane can take a word if it is empty or is draining now;
   // the other lane's state never gates acceptance.
   assign in_ready = ~lane_valid[in_sel] | lane_ready[in_sel];
   assign acc      = in_valid & in_ready;

   for (genvar k = 0; k < DEMUX_NOUT; k++) begin : g_lane
      assign lane_load[k]  = acc & (in_sel == 1'(k));
      assign lane_drain[k] = lane_valid[k] & lane_ready[k];

      demux_slot_64 #(
         .WIDTH(WIDTH)
      ) u_slot (
         .clk       (clk),
         .reset     (reset),
         .load      (lane_load[k]),
         .load_data (in_data),
         .drain     (lane_drain[k]),
         .valid     (lane_valid[k]),
         .data      (lane_data[k])
      );
   end

   assign out0_valid = lane_valid[0];
   assign out0_data  = lane_data[0];
   assign out1_valid = lane_valid[1];
   assign out1_data  = lane_data[1];

`ifdef DEMUX_ROUTE_COUNT_EN
   // Delivered-word counters: bump on each lane drain, wrap naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (lane_drain[0]) cnt0 <= cnt0 + DEMUX_CNT_W'(1);
         if (lane_drain[1]) cnt1 <= cnt1 + DEMUX_CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_demux_64x1x2_reg.sv
// Bench for demux_64x1x2_reg: directed vectors with literal expectations plus
// a per-lane queue model compared against the outputs on every falling edge.
module tb_demux_64x1x2_reg;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] in_data = '0;
   logic        in_sel = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] out0_data;
   logic        out0_valid;
   logic        out0_ready = 1'b0;
   logic [63:0] out1_data;
   logic        out1_valid;
   logic        out1_ready = 1'b0;
`ifdef DEMUX_ROUTE_COUNT_EN
   logic [15:0] cnt0;
   logic [15:0] cnt1;
`endif

   int tests = 0;
   int fails = 0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   demux_64x1x2_reg dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out0_data  (out0_data),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out1_data  (out1_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready)
`ifdef DEMUX_ROUTE_COUNT_EN
      ,
      .cnt0       (cnt0),
      .cnt1       (cnt1)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model / scoreboard ----------------
   // Words accepted but not yet delivered, per lane, plus the last delivered
   // word (what the lane must show once it empties).
   logic [63:0] exp_q0[$];
   logic [63:0] exp_q1[$];
   logic [63:0] last0 = '0;
   logic [63:0] last1 = '0;
   int          m_cnt0 = 0;
   int          m_cnt1 = 0;

   always @(negedge clk) begin
      logic exp_ready;
      logic dr0, dr1;
      if (reset) begin
         exp_q0.delete(); exp_q1.delete();
         last0 = '0; last1 = '0; m_cnt0 = 0; m_cnt1 = 0;
      end
      check("m_out0_valid", 64'(out0_valid), 64'(exp_q0.size() != 0));
      check("m_out1_valid", 64'(out1_valid), 64'(exp_q1.size() != 0));
      check("m_out0_data", out0_data, (exp_q0.size() != 0) ? exp_q0[0] : last0);
      check("m_out1_data", out1_data, (exp_q1.size() != 0) ? exp_q1[0] : last1);
      exp_ready = in_sel ? ((exp_q1.size() == 0) || out1_ready)
                         : ((exp_q0.size() == 0) || out0_ready);
      check("m_in_ready", 64'(in_ready), 64'(exp_ready));
`ifdef DEMUX_ROUTE_COUNT_EN
      check("m_cnt0", 64'(cnt0), 64'(m_cnt0 % 65536));
      check("m_cnt1", 64'(cnt1), 64'(m_cnt1 % 65536));
`endif
      if (!reset) begin
         dr0 = (exp_q0.size() != 0) && out0_ready;
         dr1 = (exp_q1.size() != 0) && out1_ready;
         if (dr0) begin last0 = exp_q0.pop_front(); m_cnt0++; end
         if (dr1) begin last1 = exp_q1.pop_front(); m_cnt1++; end
         if (in_valid && exp_ready) begin
            if (in_sel) exp_q1.push_back(in_data);
            else        exp_q0.push_back(in_data);
         end
      end
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic sel, input logic [63:0] d);
      in_sel   = sel;
      in_data  = d;
      in_valid = 1'b1;
   endtask

   initial begin
      repeat (2) tick();
      check("rst_out0_valid", 64'(out0_valid), 64'd0);
      check("rst_out1_valid", 64'(out1_valid), 64'd0);
      check("rst_out0_data", out0_data, 64'd0);
      check("rst_out1_data", out1_data, 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      reset = 1'b0;

      // Single word to lane 1.
      out1_ready = 1'b1;
      offer(1'b1, 64'h0123_4567_89AB_CDEF);
      tick();
      in_valid = 1'b0;
      check("t1_out1_valid", 64'(out1_valid), 64'd1);
      check("t1_out1_data", out1_data, 64'h0123_4567_89AB_CDEF);
      check("t1_out0_valid", 64'(out0_valid), 64'd0);
      tick();
      check("t1_out1_drained", 64'(out1_valid), 64'd0);
      check("t1_out1_data_kept", out1_data, 64'h0123_4567_89AB_CDEF);

      // Stall lane 0, lane 1 keeps flowing.
      out0_ready = 1'b0;
      offer(1'b0, 64'hA);
      tick();
      check("t2_out0_valid", 64'(out0_valid), 64'd1);
      check("t2_out0_data", out0_data, 64'hA);
      in_valid = 1'b0;
      in_sel = 1'b0;
      #1 check("t2_ready_sel0", 64'(in_ready), 64'd0);
      in_sel = 1'b1;
      #1 check("t2_ready_sel1", 64'(in_ready), 64'd1);
      offer(1'b1, 64'hB);
      tick();
      in_valid = 1'b0;
      check("t2_out1_valid", 64'(out1_valid), 64'd1);
      check("t2_out1_data", out1_data, 64'hB);
      check("t2_out0_held", out0_data, 64'hA);
      tick();
      check("t2_out1_drained", 64'(out1_valid), 64'd0);
      check("t2_out0_still", 64'(out0_valid), 64'd1);
      check("t2_out0_stable", out0_data, 64'hA);

      // Back-to-back on lane 0 with no bubble.
      out0_ready = 1'b1;
      offer(1'b0, 64'h1);
      tick();
      check("t3_valid_1", 64'(out0_valid), 64'd1);
      check("t3_data_1", out0_data, 64'h1);
      offer(1'b0, 64'h2);
      tick();
      in_valid = 1'b0;
      check("t3_valid_2", 64'(out0_valid), 64'd1);
      check("t3_data_2", out0_data, 64'h2);
      tick();
      check("t3_drained", 64'(out0_valid), 64'd0);

      // Asynchronous reset with both lanes full.
      out0_ready = 1'b0;
      out1_ready = 1'b0;
      offer(1'b0, 64'h55);
      tick();
      offer(1'b1, 64'h66);
      tick();
      in_valid = 1'b0;
      check("t4_full0", 64'(out0_valid), 64'd1);
      check("t4_full1", 64'(out1_valid), 64'd1);
      #2 reset = 1'b1;
      #1;
      check("t4_async_v0", 64'(out0_valid), 64'd0);
      check("t4_async_v1", 64'(out1_valid), 64'd0);
      check("t4_async_d0", out0_data, 64'd0);
      tick();
      reset = 1'b0;
      #1 check("t4_ready_after", 64'(in_ready), 64'd1);
      offer(1'b0, 64'h77);
      tick();
      in_valid = 1'b0;
      check("t4_first_accept_v", 64'(out0_valid), 64'd1);
      check("t4_first_accept_d", out0_data, 64'h77);

      // Random traffic, checked by the model.
      for (int i = 0; i < 10000; i++) begin
         in_valid   = 1'($urandom_range(0, 1));
         in_sel     = 1'($urandom_range(0, 1));
         in_data    = {$urandom, $urandom};
         out0_ready = 1'($urandom_range(0, 1));
         out1_ready = 1'($urandom_range(0, 1));
         tick();
      end
      in_valid   = 1'b0;
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      repeat (3) tick();
      check("rnd_end_v0", 64'(out0_valid), 64'd0);
      check("rnd_end_v1", 64'(out1_valid), 64'd0);

`ifdef DEMUX_ROUTE_COUNT_EN
      // Counter wrap on lane 1.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      out0_ready = 1'b0;
      for (int i = 0; i < 65537; i++) begin
         offer(1'b1, 64'(i));
         tick();
      end
      in_valid = 1'b0;
      tick();
      check("cnt1_wrap", 64'(cnt1), 64'd1);
      check("cnt0_zero", 64'(cnt0), 64'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
